// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: access-size codes, FSM state encoding, the control bundle
// carried through the stage, and the lane/extension helpers shared by the
// MEM stage top level.
package mem_stage_pkg;

  // Access-size codes on in_load_mode (code 2'b11 is treated as a word).
  localparam logic [1:0] LD_WORD = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_BYTE = 2'b10;

  // Stage FSM encoding.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  // Width-independent control fields of one EX/MEM slot.
  typedef struct packed {
    logic       valid;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       zero;
    logic [1:0] mode;
    logic       is_unsigned;
    logic [4:0] rd;
  } ctrl_t;

  // Number of bytes touched by an access; a "word" is the full datapath.
  function automatic int unsigned access_bytes(input logic [1:0] mode,
                                               input int unsigned lanes);
    case (mode)
      LD_WORD: access_bytes = lanes;
      LD_HALF: access_bytes = 2;
      LD_BYTE: access_bytes = 1;
      default: access_bytes = lanes;
    endcase
  endfunction

  // Lane offset rounded down to the natural alignment of the access.
  function automatic int unsigned align_offset(input int unsigned offset,
                                               input int unsigned nbytes);
    align_offset = offset & ~(nbytes - 1);
  endfunction

  // Byte enable of one lane for an access of nbytes starting at offset.
  function automatic logic lane_enable(input int unsigned lane,
                                       input int unsigned offset,
                                       input int unsigned nbytes);
    lane_enable = (lane >= offset) && (lane < offset + nbytes);
  endfunction

  // Filler byte for the upper part of an extended sub-word load.
  function automatic logic [7:0] fill_byte(input logic sign,
                                           input logic zero_ext);
    fill_byte = (sign && !zero_ext) ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/mem_stage_ram.sv
// mem_stage_ram: synchronous single-port data RAM, MEM_DEPTH x DATA_W, with
// per-byte write enables. Read data is registered; contents are never reset,
// only the read register is.
module mem_stage_ram
  import mem_stage_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int MEM_DEPTH = 256,
  localparam int LANES     = DATA_W / 8,
  localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LANES-1:0]  be,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Byte-lane writes; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < LANES; j++) begin
        if (be[j]) mem[idx][8*j +: 8] <= wdata[8*j +: 8];
      end
    end
  end

  // Registered read port, cleared by reset so read data starts at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/mem_stage_pipelined.sv
// mem_stage_pipelined: MIPS MEM stage with a multi-cycle data RAM.
//   - Resolves branches (pc_src), performs byte/half/word loads and stores,
//     and drives the registered MEM/WB boundary.
//   - A memory op with MEM_LAT>1 holds the stage in ACCESS and raises stall
//     for MEM_LAT-1 cycles; the RAM access and the MEM/WB update happen on
//     the final edge of the op ("commit" edge).
//   - Optional macro MEM_STAGE_ALIGN_EXC_EN: flags misaligned half/word
//     accesses on the misaligned port instead of aligning them down.
//
// Handshake: stall is combinational. While stall=1 the upstream stage must
// keep every in_* input stable; the slot is consumed on the first rising edge
// at which stall=0. Each edge that is not a commit edge writes a bubble
// (out_valid=0, reg_write_out=0, pc_src=0) into MEM/WB.
module mem_stage_pipelined
  import mem_stage_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 256,
  parameter int MEM_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic              in_branch,
  input  logic              in_zero,
  input  logic [1:0]        in_load_mode,
  input  logic              in_load_unsigned,
  input  logic [ADDR_W-1:0] in_address,
  input  logic [DATA_W-1:0] in_write_data,
  input  logic [4:0]        in_rd,
  output logic              stall,
  output logic              pc_src,
  output logic              out_valid,
  output logic              reg_write_out,
  output logic              mem_to_reg_out,
  output logic [DATA_W-1:0] read_data,
  output logic [ADDR_W-1:0] address_out,
  output logic [4:0]        rd_out
`ifdef MEM_STAGE_ALIGN_EXC_EN
  ,
  output logic              misaligned
`endif
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int          LB    = $clog2(DATA_W / 8);
  localparam int          IDX_W = $clog2(MEM_DEPTH);
  localparam logic [2:0]  LAST  = 3'(MEM_LAT - 1);
  localparam logic        MULTI = (MEM_LAT > 1);

  // FSM and latency counter
  logic [0:0] state;
  logic [2:0] cnt;

  // Slot currently being served: live inputs in IDLE, held copy in ACCESS
  ctrl_t             in_ctrl, held_ctrl, cur;
  logic [ADDR_W-1:0] held_addr, cur_addr;
  logic [DATA_W-1:0] held_wdata, cur_wdata;

  logic is_mem, is_store, is_load, mis_now, commit;

  // RAM interface
  logic [LANES-1:0]  ram_be;
  logic              ram_re;
  logic [IDX_W-1:0]  ram_idx;
  logic [DATA_W-1:0] ram_wdata, ram_q;
  int unsigned       st_nb, st_off;

  // Load-format information registered alongside MEM/WB
  logic          wb_load;
  logic [1:0]    wb_mode;
  logic          wb_unsigned;
  logic [LB-1:0] wb_off;
  int unsigned   ld_nb, ld_off;
  logic          ld_sign;

  assign in_ctrl = '{
    valid:       in_valid,
    mem_read:    in_mem_read,
    mem_write:   in_mem_write,
    reg_write:   in_reg_write,
    mem_to_reg:  in_mem_to_reg,
    branch:      in_branch,
    zero:        in_zero,
    mode:        in_load_mode,
    is_unsigned: in_load_unsigned,
    rd:          in_rd
  };

  // Select the slot being served and classify it.
  always_comb begin
    cur       = in_ctrl;
    cur_addr  = in_address;
    cur_wdata = in_write_data;
    if (state == ST_ACCESS) begin
      cur       = held_ctrl;
      cur_addr  = held_addr;
      cur_wdata = held_wdata;
    end
    is_mem   = cur.valid & (cur.mem_read | cur.mem_write);
    // A slot with both read and write set is a store.
    is_store = cur.valid & cur.mem_write;
    is_load  = cur.valid & cur.mem_read & ~cur.mem_write;
  end

`ifdef MEM_STAGE_ALIGN_EXC_EN
  // Half with addr[0] set, or full word not on a word boundary.
  always_comb begin
    mis_now = 1'b0;
    if (is_mem) begin
      if (cur.mode == LD_HALF) begin
        mis_now = cur_addr[0];
      end else if (cur.mode != LD_BYTE) begin
        mis_now = (cur_addr[LB-1:0] != '0);
      end
    end
  end
`else
  assign mis_now = 1'b0;
`endif

  // Commit edge: the single edge on which a slot reaches MEM/WB.
  always_comb begin
    if (state == ST_IDLE) begin
      commit = ~(is_mem & MULTI);
      stall  = ~rst & is_mem & MULTI;
    end else begin
      commit = (cnt == LAST);
      stall  = ~rst & (cnt != LAST);
    end
  end

  // IDLE/ACCESS sequencing; the slot is copied on every IDLE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      held_ctrl  <= '0;
      held_addr  <= '0;
      held_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          held_ctrl  <= in_ctrl;
          held_addr  <= in_address;
          held_wdata <= in_write_data;
          if (is_mem && MULTI) begin
            state <= ST_ACCESS;
            cnt   <= 3'd1;
          end
        end
        default: begin
          if (cnt == LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= 3'(cnt + 3'd1);
          end
        end
      endcase
    end
  end

  // Byte enables and lane-replicated store data for the commit edge.
  always_comb begin
    ram_be    = '0;
    ram_wdata = '0;
    st_nb     = access_bytes(cur.mode, LANES);
    st_off    = align_offset(32'(cur_addr[LB-1:0]), st_nb);
    for (int unsigned j = 0; j < LANES; j++) begin
      ram_wdata[8*j +: 8] = cur_wdata[8*(j & (st_nb - 1)) +: 8];
      if (commit && is_store && !mis_now) begin
        ram_be[j] = lane_enable(j, st_off, st_nb);
      end
    end
  end

  assign ram_re  = commit & is_load & ~mis_now;
  assign ram_idx = cur_addr[IDX_W+LB-1:LB];

  mem_stage_ram #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .be    (ram_be),
    .re    (ram_re),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  // MEM/WB boundary: written on commit, bubbled on every other edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      reg_write_out  <= 1'b0;
      mem_to_reg_out <= 1'b0;
      pc_src         <= 1'b0;
      address_out    <= '0;
      rd_out         <= '0;
      wb_load        <= 1'b0;
      wb_mode        <= LD_WORD;
      wb_unsigned    <= 1'b0;
      wb_off         <= '0;
    end else if (commit) begin
      out_valid      <= cur.valid;
      reg_write_out  <= cur.valid & cur.reg_write & ~mis_now;
      mem_to_reg_out <= cur.mem_to_reg;
      pc_src         <= cur.valid & cur.branch & cur.zero;
      address_out    <= cur_addr;
      rd_out         <= cur.rd;
      wb_load        <= is_load & ~mis_now;
      wb_mode        <= cur.mode;
      wb_unsigned    <= cur.is_unsigned;
      wb_off         <= cur_addr[LB-1:0];
    end else begin
      out_valid     <= 1'b0;
      reg_write_out <= 1'b0;
      pc_src        <= 1'b0;
      wb_load       <= 1'b0;
    end
  end

`ifdef MEM_STAGE_ALIGN_EXC_EN
  // Misaligned flag travels with out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      misaligned <= 1'b0;
    end else if (commit) begin
      misaligned <= cur.valid & mis_now;
    end else begin
      misaligned <= 1'b0;
    end
  end
`endif

  // Lane select and sign/zero extension of the registered RAM word.
  always_comb begin
    read_data = '0;
    ld_nb     = access_bytes(wb_mode, LANES);
    ld_off    = align_offset(32'(wb_off), ld_nb);
    ld_sign   = ram_q[8*(ld_off + ld_nb) - 1];
    if (wb_load) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        if (j < ld_nb) begin
          read_data[8*j +: 8] = ram_q[8*((ld_off + j) & (LANES - 1)) +: 8];
        end else begin
          read_data[8*j +: 8] = fill_byte(ld_sign, wb_unsigned);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_pipelined.sv
// tb_mem_stage_pipelined: table-driven directed vectors, hand-written reset,
// branch and abort sequences, then randomized ops checked against a
// byte-addressed memory model. Build with +define+MEM_STAGE_ALIGN_EXC_EN to
// exercise the misaligned-access variant.
`timescale 1ns/1ps
module tb_mem_stage_pipelined;

  localparam int LAT = 3;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_mem_read, in_mem_write, in_reg_write;
  logic        in_mem_to_reg, in_branch, in_zero, in_load_unsigned;
  logic [1:0]  in_load_mode;
  logic [31:0] in_address, in_write_data;
  logic [4:0]  in_rd;
  logic        stall, pc_src, out_valid, reg_write_out, mem_to_reg_out;
  logic [31:0] read_data, address_out;
  logic [4:0]  rd_out;
`ifdef MEM_STAGE_ALIGN_EXC_EN
  logic        misaligned;
`endif

  always #5 clk = ~clk;

  mem_stage_pipelined #(
    .DATA_W    (32),
    .ADDR_W    (32),
    .MEM_DEPTH (256),
    .MEM_LAT   (LAT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_mem_read      (in_mem_read),
    .in_mem_write     (in_mem_write),
    .in_reg_write     (in_reg_write),
    .in_mem_to_reg    (in_mem_to_reg),
    .in_branch        (in_branch),
    .in_zero          (in_zero),
    .in_load_mode     (in_load_mode),
    .in_load_unsigned (in_load_unsigned),
    .in_address       (in_address),
    .in_write_data    (in_write_data),
    .in_rd            (in_rd),
    .stall            (stall),
    .pc_src           (pc_src),
    .out_valid        (out_valid),
    .reg_write_out    (reg_write_out),
    .mem_to_reg_out   (mem_to_reg_out),
    .read_data        (read_data),
    .address_out      (address_out),
    .rd_out           (rd_out)
`ifdef MEM_STAGE_ALIGN_EXC_EN
    ,
    .misaligned       (misaligned)
`endif
  );

  // ---------------- types ----------------
  typedef struct {
    logic        valid, rd_en, wr_en, regw, m2r, br, zero, uns;
    logic [1:0]  mode;
    logic [31:0] addr, wdata;
    logic [4:0]  rdr;
  } op_t;

  typedef struct {
    op_t         op;
    int          exp_stalls;
    logic [31:0] exp_data;
  } vec_t;

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  ref_mem [1024];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (byte-addressed memory) ----------------
  function automatic int size_of(input logic [1:0] mode);
    if (mode == 2'b01) return 2;
    if (mode == 2'b10) return 1;
    return 4;
  endfunction

  function automatic logic is_mis(input logic [31:0] addr, input logic [1:0] mode);
`ifdef MEM_STAGE_ALIGN_EXC_EN
    int s = size_of(mode);
    return (s == 2 && addr[0]) || (s == 4 && addr[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [1:0] mode, input logic [31:0] data);
    int s = size_of(mode);
    int a = (int'(addr % 1024) / s) * s;
    for (int i = 0; i < s; i++) ref_mem[a + i] = data[8*i +: 8];
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] mode, input logic uns);
    int s = size_of(mode);
    int a = (int'(addr % 1024) / s) * s;
    logic [31:0] v = '0;
    for (int i = 0; i < s; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
    if (s < 4 && !uns && v[8*s - 1]) v = v | (32'hFFFF_FFFF << (8 * s));
    return v;
  endfunction

  function automatic op_t mk(input logic rd_en, input logic wr_en, input logic regw,
                             input logic m2r, input logic [1:0] mode, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [4:0] rdr);
    op_t o;
    o.valid = 1'b1; o.rd_en = rd_en; o.wr_en = wr_en; o.regw = regw; o.m2r = m2r;
    o.br = 1'b0; o.zero = 1'b0; o.uns = uns; o.mode = mode;
    o.addr = addr; o.wdata = wdata; o.rdr = rdr;
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input op_t o);
    in_valid = o.valid;       in_mem_read = o.rd_en;  in_mem_write = o.wr_en;
    in_reg_write = o.regw;    in_mem_to_reg = o.m2r;  in_branch = o.br;
    in_zero = o.zero;         in_load_mode = o.mode;  in_load_unsigned = o.uns;
    in_address = o.addr;      in_write_data = o.wdata; in_rd = o.rdr;
  endtask

  task automatic drive_idle();
    op_t o = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
    o.valid = 1'b0;
    drive(o);
  endtask

  // Present one slot (called #1 after a rising edge), follow the stall
  // handshake, then check the MEM/WB outputs after the consuming edge.
  task automatic run_op(input string tag, input op_t o, input int exp_stalls, input logic [31:0] exp_data);
    int          stalls = 0;
    logic        mis    = o.valid & (o.rd_en | o.wr_en) & is_mis(o.addr, o.mode);
    logic [31:0] got_exp;
    exp_q.push_back(exp_data);
    drive(o);
    #1;
    while (stall === 1'b1 && stalls < 20) begin
      @(posedge clk); #1;
      stalls++;
    end
    check({tag, " stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    @(posedge clk); #1;
    got_exp = exp_q.pop_front();
    check({tag, " out_valid"}, 32'(out_valid), 32'(o.valid));
    check({tag, " reg_write_out"}, 32'(reg_write_out), 32'(o.valid & o.regw & ~mis));
    check({tag, " pc_src"}, 32'(pc_src), 32'(o.valid & o.br & o.zero));
    if (o.valid) begin
      check({tag, " mem_to_reg_out"}, 32'(mem_to_reg_out), 32'(o.m2r));
      check({tag, " address_out"}, address_out, o.addr);
      check({tag, " rd_out"}, 32'(rd_out), 32'(o.rdr));
    end
`ifdef MEM_STAGE_ALIGN_EXC_EN
    check({tag, " misaligned"}, 32'(misaligned), 32'(mis));
`endif
    if (o.valid && o.rd_en && !o.wr_en && !mis) check({tag, " read_data"}, read_data, got_exp);
    if (o.valid && o.wr_en && !mis) model_store(o.addr, o.mode, o.wdata);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " stall"}, 32'(stall), 32'd0);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " reg_write_out"}, 32'(reg_write_out), 32'd0);
    check({tag, " mem_to_reg_out"}, 32'(mem_to_reg_out), 32'd0);
    check({tag, " pc_src"}, 32'(pc_src), 32'd0);
    check({tag, " read_data"}, read_data, 32'd0);
    check({tag, " address_out"}, address_out, 32'd0);
    check({tag, " rd_out"}, 32'(rd_out), 32'd0);
`ifdef MEM_STAGE_ALIGN_EXC_EN
    check({tag, " misaligned"}, 32'(misaligned), 32'd0);
`endif
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test ----------------
  vec_t tbl[19];

  initial begin
    op_t o;

    tbl[0]  = '{mk(0,1,0,0,2'b00,0,32'h10,32'hDEADBEEF,5'd0), 2, 32'h0};
    tbl[1]  = '{mk(1,0,1,1,2'b00,0,32'h10,32'h0,5'd3),        2, 32'hDEADBEEF};
    tbl[2]  = '{mk(0,1,0,0,2'b10,0,32'h13,32'h00000080,5'd0), 2, 32'h0};
    tbl[3]  = '{mk(1,0,1,1,2'b10,0,32'h13,32'h0,5'd4),        2, 32'hFFFFFF80};
    tbl[4]  = '{mk(1,0,1,1,2'b10,1,32'h13,32'h0,5'd5),        2, 32'h00000080};
    tbl[5]  = '{mk(1,0,1,1,2'b00,0,32'h10,32'h0,5'd6),        2, 32'h80ADBEEF};
    tbl[6]  = '{mk(1,0,1,1,2'b11,1,32'h10,32'h0,5'd7),        2, 32'h80ADBEEF};
    tbl[7]  = '{mk(1,0,1,1,2'b00,0,32'h410,32'h0,5'd8),       2, 32'h80ADBEEF};
    tbl[8]  = '{mk(0,1,0,0,2'b00,0,32'h20,32'h7FFF8001,5'd0), 2, 32'h0};
    tbl[9]  = '{mk(1,0,1,1,2'b01,0,32'h21,32'h0,5'd9),        2, 32'hFFFF8001};
    tbl[10] = '{mk(1,0,1,1,2'b01,0,32'h22,32'h0,5'd10),       2, 32'h00007FFF};
    tbl[11] = '{mk(1,0,1,1,2'b01,1,32'h20,32'h0,5'd11),       2, 32'h00008001};
    tbl[12] = '{mk(1,1,0,0,2'b00,0,32'h30,32'hCAFEF00D,5'd0), 2, 32'h0};
    tbl[13] = '{mk(1,0,1,1,2'b00,0,32'h30,32'h0,5'd12),       2, 32'hCAFEF00D};
    tbl[14] = '{mk(0,0,1,0,2'b00,0,32'h12345678,32'h0,5'd13), 0, 32'h0};
    tbl[15] = '{mk(0,1,1,0,2'b00,0,32'h30,32'h0,5'd14),       0, 32'h0};
    tbl[15].op.valid = 1'b0;
    tbl[16] = '{mk(1,0,1,1,2'b00,0,32'h30,32'h0,5'd15),       2, 32'hCAFEF00D};
    tbl[17] = '{mk(0,1,0,0,2'b10,0,32'h31,32'h0000005A,5'd0), 2, 32'h0};
    tbl[18] = '{mk(1,0,1,1,2'b01,1,32'h30,32'h0,5'd16),       2, 32'h00005A0D};

    // Reset held for two cycles.
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    rst = 1'b0;

    // Give every RAM word a known value so the model covers all loads.
    for (int k = 0; k < 256; k++) begin
      o = mk(0, 1, 0, 0, 2'b00, 0, 32'(4 * k), 32'h0, 5'd0);
      run_op($sformatf("init%0d", k), o, LAT - 1, 32'h0);
    end

    // Directed vectors.
    for (int i = 0; i < 19; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].exp_stalls, tbl[i].exp_data);
    end

    // Taken branch: pc_src for one cycle only; untaken branch: never.
    o = mk(0, 0, 0, 0, 2'b00, 0, 32'h40, 32'h0, 5'd0);
    o.br = 1'b1; o.zero = 1'b1;
    run_op("br_taken", o, 0, 32'h0);
    o.valid = 1'b0; o.br = 1'b0; o.zero = 1'b0;
    run_op("br_after", o, 0, 32'h0);
    o = mk(0, 0, 0, 0, 2'b00, 0, 32'h44, 32'h0, 5'd0);
    o.br = 1'b1; o.zero = 1'b0;
    run_op("br_untaken", o, 0, 32'h0);

    // Reset in the final access cycle of a store drops the store.
    drive(mk(0, 1, 0, 0, 2'b00, 0, 32'h20, 32'h12345678, 5'd0));
    @(posedge clk); #1;
    check("abort stall_in_access", 32'(stall), 32'd1);
    @(posedge clk); #1;
    check("abort final_cycle_stall", 32'(stall), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_cleared("abort");
    rst = 1'b0;
    drive_idle();
    run_op("abort_reload", mk(1, 0, 1, 1, 2'b00, 0, 32'h20, 32'h0, 5'd1), LAT - 1, 32'h7FFF8001);

    // Randomized slots against the byte-addressed model.
    for (int n = 0; n < 300; n++) begin
      op_t r;
      int  kind;
      kind    = $urandom_range(0, 3);
      r.valid = ($urandom_range(0, 9) != 0);
      r.rd_en = (kind == 0 || kind == 2);
      r.wr_en = (kind == 1 || kind == 2);
      r.regw  = 1'($urandom_range(0, 1));
      r.m2r   = 1'($urandom_range(0, 1));
      r.br    = 1'($urandom_range(0, 1));
      r.zero  = 1'($urandom_range(0, 1));
      r.uns   = 1'($urandom_range(0, 1));
      r.mode  = 2'($urandom_range(0, 3));
      r.addr  = $urandom();
      r.wdata = $urandom();
      r.rdr   = 5'($urandom_range(0, 31));
      run_op($sformatf("rnd%0d", n), r,
             (r.valid && (r.rd_en || r.wr_en)) ? LAT - 1 : 0,
             model_load(r.addr, r.mode, r.uns));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
